// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and FSM states for the stereo frame-buffer write arbiter.
package fb_pkg;
  localparam int FB_FRAME_PIX = 19200;
  localparam logic [1:0] REGION_L = 2'b00;
  localparam logic [1:0] REGION_R = 2'b01;
  localparam logic [1:0] REGION_D = 2'b10;
  typedef enum logic [1:0] {FILL, READY, SWAP} fb_state_e;
endpackage

// File: rtl/rr_arb3.sv
// rr_arb3: three-way round-robin arbiter; the index granted last has lowest priority.
module rr_arb3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] gnt
);
  logic [1:0] r_last;
  logic [1:0] w_p0;
  logic [1:0] w_p1;
  assign w_p0 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
  assign w_p1 = (w_p0 == 2'd2) ? 2'd0 : w_p0 + 2'd1;
  always_comb begin
    gnt = '0;
    if (req[w_p0]) gnt[w_p0] = 1'b1;
    else if (req[w_p1]) gnt[w_p1] = 1'b1;
    else if (req[r_last]) gnt[r_last] = 1'b1;
  end
  // Reset value makes L the first index in priority order.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_last <= 2'd2;
    else if (advance && |gnt) r_last <= gnt[0] ? 2'd0 : gnt[1] ? 2'd1 : 2'd2;
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: merges L/R/disparity pixel writes into a double-buffered frame store.
// Define FB_WR_STATS_EN to add the swap_cnt / late_cnt statistics outputs.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16,
  parameter int FRAME_PIX = FB_FRAME_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid_L,
  output logic              wr_ready_L,
  input  logic [ADDR_W-1:0] wr_addr_L,
  input  logic [DATA_W-1:0] wr_data_L,
  input  logic              wr_last_L,
  input  logic              wr_valid_R,
  output logic              wr_ready_R,
  input  logic [ADDR_W-1:0] wr_addr_R,
  input  logic [DATA_W-1:0] wr_data_R,
  input  logic              wr_last_R,
  input  logic              wr_valid_D,
  output logic              wr_ready_D,
  input  logic [ADDR_W-1:0] wr_addr_D,
  input  logic [DATA_W-1:0] wr_data_D,
  input  logic              wr_last_D,
  output logic              mem_we,
  output logic [ADDR_W+2:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              vsync,
  output logic              rd_bank,
  output logic              addr_err
`ifdef FB_WR_STATS_EN
  ,
  output logic [15:0]       swap_cnt,
  output logic [15:0]       late_cnt
`endif
);
  fb_state_e         r_state;
  fb_state_e         w_state_nxt;
  logic [2:0]        r_done;
  logic [2:0]        w_req;
  logic [2:0]        w_gnt;
  logic [2:0]        w_done_nxt;
  logic              r_rd_bank;
  logic              r_vsync_q;
  logic              r_we;
  logic              r_addr_err;
  logic [ADDR_W+2:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_region;
  logic              w_grant;
  logic              w_oob;
  logic              w_vs_edge;
  logic              w_unused;

  assign w_req = {wr_valid_D, wr_valid_R, wr_valid_L} & ~r_done & {3{r_state == FILL}};

  rr_arb3 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_grant),
    .gnt     (w_gnt)
  );

  assign {wr_ready_D, wr_ready_R, wr_ready_L} = w_gnt;
  assign w_grant    = |w_gnt;
  assign w_addr     = w_gnt[0] ? wr_addr_L : w_gnt[1] ? wr_addr_R : wr_addr_D;
  assign w_data     = w_gnt[0] ? wr_data_L : w_gnt[1] ? wr_data_R : {{(DATA_W-8){1'b0}}, wr_data_D[7:0]};
  assign w_region   = w_gnt[0] ? REGION_L : w_gnt[1] ? REGION_R : REGION_D;
  assign w_oob      = 32'(w_addr) >= FRAME_PIX;
  assign w_done_nxt = r_done | (w_gnt & {wr_last_D, wr_last_R, wr_last_L});
  assign w_vs_edge  = vsync & ~r_vsync_q;
  assign w_unused   = ^wr_data_D[DATA_W-1:8];

  // Entering READY on the grant that completes the frame means a vsync edge in that same cycle is still seen in FILL and ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    w_state_nxt = &w_done_nxt ? READY : FILL;
      READY:   w_state_nxt = w_vs_edge ? SWAP : READY;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= FILL;
      r_done     <= '0;
      r_rd_bank  <= 1'b0;
      r_vsync_q  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_vsync_q  <= vsync;
      r_done     <= (r_state == SWAP) ? 3'b000 : w_done_nxt;
      r_rd_bank  <= r_rd_bank ^ (r_state == SWAP);
      r_we       <= w_grant & ~w_oob;
      r_addr_err <= r_addr_err | (w_grant & w_oob);
      if (w_grant) begin
        r_addr  <= {~r_rd_bank, w_region, w_addr};
        r_wdata <= w_data;
      end
    end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rd_bank   = r_rd_bank;
  assign addr_err  = r_addr_err;

`ifdef FB_WR_STATS_EN
  logic [15:0] r_swap_cnt;
  logic [15:0] r_late_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_swap_cnt <= '0;
      r_late_cnt <= '0;
    end else begin
      if (r_state == SWAP) r_swap_cnt <= r_swap_cnt + 16'd1;
      if (r_state == FILL && w_vs_edge && r_late_cnt != 16'hFFFF) r_late_cnt <= r_late_cnt + 16'd1;
    end
  assign swap_cnt = r_swap_cnt;
  assign late_cnt = r_late_cnt;
`endif
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: table vectors plus corner sequences, with a write scoreboard and behavioural model.
module tb_fb_write_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int FP = 19200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0;
  logic [2:0] v = '0;
  logic [2:0] lst = '0;
  logic [AW-1:0] a [3];
  logic [DW-1:0] d [3];
  logic wr_valid_L, wr_ready_L, wr_last_L, wr_valid_R, wr_ready_R, wr_last_R, wr_valid_D, wr_ready_D, wr_last_D;
  logic [AW-1:0] wr_addr_L, wr_addr_R, wr_addr_D;
  logic [DW-1:0] wr_data_L, wr_data_R, wr_data_D;
  logic mem_we, rd_bank, addr_err;
  logic [AW+2:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  assign {wr_valid_D, wr_valid_R, wr_valid_L} = v;
  assign {wr_last_D, wr_last_R, wr_last_L} = lst;
  assign wr_addr_L = a[0];
  assign wr_addr_R = a[1];
  assign wr_addr_D = a[2];
  assign wr_data_L = d[0];
  assign wr_data_R = d[1];
  assign wr_data_D = d[2];

  fb_write_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_valid_L(wr_valid_L), .wr_ready_L(wr_ready_L), .wr_addr_L(wr_addr_L), .wr_data_L(wr_data_L), .wr_last_L(wr_last_L),
    .wr_valid_R(wr_valid_R), .wr_ready_R(wr_ready_R), .wr_addr_R(wr_addr_R), .wr_data_R(wr_data_R), .wr_last_R(wr_last_R),
    .wr_valid_D(wr_valid_D), .wr_ready_D(wr_ready_D), .wr_addr_D(wr_addr_D), .wr_data_D(wr_data_D), .wr_last_D(wr_last_D),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .vsync(vsync), .rd_bank(rd_bank), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic we; logic [AW+2:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct {logic [2:0] v; logic [2:0] exp;} vec_t;
  wr_t sbq [$];
  vec_t tbl [12];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_state, m_last;
  logic [2:0] m_done;
  logic m_bank, m_vq, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] model_grant();
    if (m_state != 0) return 3'b000;
    for (int k = 1; k <= 3; k++) begin
      int i = (m_last + k) % 3;
      if (v[i] && !m_done[i]) return 3'b001 << i;
    end
    return 3'b000;
  endfunction

  // One clock: sample at the falling edge, score, advance the model, return #1 after the next rising edge.
  task automatic tick(output logic [2:0] rdy);
    logic [2:0] eg;
    wr_t e;
    int i;
    #4;
    eg = model_grant();
    rdy = {wr_ready_D, wr_ready_R, wr_ready_L};
    chk("ready", 32'(rdy), 32'(eg));
    chk("rd_bank", 32'(rd_bank), 32'(m_bank));
    chk("addr_err", 32'(addr_err), 32'(m_err));
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("mem_we", 32'(mem_we), 32'(e.we));
      if (e.we) begin
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
      end
    end else chk("mem_we_idle", 32'(mem_we), 32'd0);
    if (eg != 3'b000) begin
      i = eg[0] ? 0 : eg[1] ? 1 : 2;
      e.due = cyc + 1;
      e.we = 32'(a[i]) < FP;
      e.addr = {~m_bank, 2'(i), a[i]};
      e.data = (i == 2) ? {8'h00, d[2][7:0]} : d[i];
      sbq.push_back(e);
      if (!e.we) m_err = 1'b1;
      if (lst[i]) m_done[i] = 1'b1;
      m_last = i;
    end
    case (m_state)
      0: if (&m_done) m_state = 1;
      1: if (vsync && !m_vq) m_state = 2;
      default: begin m_state = 0; m_bank = ~m_bank; m_done = '0; end
    endcase
    m_vq = vsync;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v = '0;
    lst = '0;
    vsync = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = 0; m_done = '0; m_bank = 1'b0; m_vq = 1'b0; m_err = 1'b0; m_last = 2;
    sbq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    logic [2:0] r;
    int cnt [3];
    for (int i = 0; i < 3; i++) begin a[i] = '0; d[i] = '0; end
    tbl[0]  = '{3'b111, 3'b001};
    tbl[1]  = '{3'b111, 3'b010};
    tbl[2]  = '{3'b111, 3'b100};
    tbl[3]  = '{3'b111, 3'b001};
    tbl[4]  = '{3'b010, 3'b010};
    tbl[5]  = '{3'b011, 3'b001};
    tbl[6]  = '{3'b110, 3'b010};
    tbl[7]  = '{3'b101, 3'b100};
    tbl[8]  = '{3'b000, 3'b000};
    tbl[9]  = '{3'b001, 3'b001};
    tbl[10] = '{3'b100, 3'b100};
    tbl[11] = '{3'b110, 3'b010};
    do_reset();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rd_bank", 32'(rd_bank), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    // Round-robin table with continuous and sparse request patterns.
    for (int k = 0; k < 12; k++) begin
      v = tbl[k].v;
      for (int i = 0; i < 3; i++) a[i] = AW'(k * 3 + i);
      d[0] = 16'hA000 + 16'(k);
      d[1] = 16'hB000 + 16'(k);
      d[2] = 16'hFF00 + 16'(k);
      tick(r);
      chk("tbl_ready", 32'(r), 32'(tbl[k].exp));
    end
    v = '0;
    tick(r);
    // Address boundary: last legal pixel writes, first illegal one is consumed but dropped.
    v = 3'b001;
    a[0] = AW'(FP - 1);
    tick(r);
    chk("edge_ready", 32'(r), 32'd1);
    chk("edge_we", 32'(mem_we), 32'd1);
    a[0] = AW'(FP);
    tick(r);
    chk("oob_ready", 32'(r), 32'd1);
    chk("oob_no_we", 32'(mem_we), 32'd0);
    chk("oob_err", 32'(addr_err), 32'd1);
    v = '0;
    repeat (3) tick(r);
    chk("oob_err_sticky", 32'(addr_err), 32'd1);
    // vsync edge while D is still filling: no swap.
    v = 3'b011; lst = 3'b011; a[0] = 15'd5; a[1] = 15'd6;
    tick(r);
    tick(r);
    v = '0; lst = '0; vsync = 1'b1;
    repeat (3) tick(r);
    chk("late_no_swap", 32'(rd_bank), 32'd0);
    v = 3'b100; a[2] = 15'd7;
    tick(r);
    chk("late_d_still_ready", 32'(r), 32'd4);
    vsync = 1'b0;
    tick(r);
    // Final last coincides with a vsync edge: edge ignored, the next one swaps.
    lst = 3'b100; vsync = 1'b1;
    tick(r);
    chk("coinc_grant", 32'(r), 32'd4);
    v = 3'b111; lst = '0;
    repeat (3) begin
      tick(r);
      chk("ready_stall", 32'(r), 32'd0);
    end
    chk("coinc_no_swap", 32'(rd_bank), 32'd0);
    vsync = 1'b0;
    tick(r);
    vsync = 1'b1;
    tick(r);
    tick(r);
    chk("swap_ready_low", 32'(r), 32'd0);
    chk("swap_bank1", 32'(rd_bank), 32'd1);
    tick(r);
    chk("resume_L_first", 32'(r), 32'd1);
    chk("resume_bank0", 32'(mem_addr[AW+2]), 32'd0);
    v = '0;
    tick(r);
    // Full frames of FP pixels per requester.
    do_reset();
    cnt = '{0, 0, 0};
    for (int n = 0; n < 60000 && !(cnt[0] == FP && cnt[1] == FP && cnt[2] == FP); n++) begin
      for (int i = 0; i < 3; i++) begin
        a[i] = AW'(cnt[i] < FP ? cnt[i] : 0);
        d[i] = DW'(cnt[i] * 3 + i);
        lst[i] = (cnt[i] == FP - 1);
        v[i] = (cnt[i] < FP);
      end
      tick(r);
      for (int i = 0; i < 3; i++) if (r[i]) cnt[i]++;
    end
    chk("frame_cnt_L", 32'(cnt[0]), 32'(FP));
    chk("frame_cnt_R", 32'(cnt[1]), 32'(FP));
    chk("frame_cnt_D", 32'(cnt[2]), 32'(FP));
    v = 3'b111; lst = '0;
    for (int i = 0; i < 3; i++) a[i] = AW'(100 + i);
    tick(r);
    chk("frame_ready_stall", 32'(r), 32'd0);
    vsync = 1'b1;
    tick(r);
    tick(r);
    chk("frame_swap_stall", 32'(r), 32'd0);
    chk("frame_bank1", 32'(rd_bank), 32'd1);
    tick(r);
    chk("frame_resume", 32'(r), 32'd1);
    chk("frame_resume_bank0", 32'(mem_addr[AW+2]), 32'd0);
    // Mid-frame reset with a registered write in flight.
    v = 3'b001; lst = 3'b001;
    tick(r);
    v = 3'b111; lst = '0;
    tick(r);
    chk("pre_rst_grant_R", 32'(r), 32'd2);
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_we", 32'(mem_we), 32'd0);
    chk("rst_bank0", 32'(rd_bank), 32'd0);
    chk("rst_addr0", 32'(mem_addr), 32'd0);
    do_reset();
    v = 3'b111;
    tick(r);
    chk("post_rst_L_first", 32'(r), 32'd1);
    v = '0;
    tick(r);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
